// File: rtl/step_dir_pulse_gen_pkg.sv
// Shared field widths and timing defaults for the STEP/DIR front end.
// The SPI command decoder imports the same widths so command fields line up.
package step_dir_pulse_gen_pkg;

  localparam int unsigned COUNT_W_DEF          = 32;
  localparam int unsigned PERIOD_W_DEF         = 32;
  localparam int unsigned STEP_HIGH_CYCLES_DEF = 8;
  localparam int unsigned DIR_SETUP_CYCLES_DEF = 16;

endpackage : step_dir_pulse_gen_pkg

// File: rtl/step_dir_pulse_gen_interval_timer.sv
// Loadable down-counter with a zero flag. It times the DIR setup wait and the
// STEP high/low phases. It holds at zero rather than wrapping.
module step_interval_timer
  import step_dir_pulse_gen_pkg::*;
#(
  parameter int unsigned WIDTH = PERIOD_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;

  // Reload on request, otherwise count down and stop at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {WIDTH{1'b0}});

endmodule : step_interval_timer

// File: rtl/step_dir_pulse_gen.sv
// Move-command front end for the microstepper STEP/DIR inputs.
// It accepts one move at a time and emits exactly timed STEP pulses.
// DIR is set up before the first rising edge of STEP.
// Completion, whether normal or aborted, is reported with a 1-cycle move_done.
module step_dir_pulse_gen
  import step_dir_pulse_gen_pkg::*;
#(
  parameter int unsigned COUNT_W          = COUNT_W_DEF,
  parameter int unsigned PERIOD_W         = PERIOD_W_DEF,
  parameter int unsigned STEP_HIGH_CYCLES = STEP_HIGH_CYCLES_DEF,
  parameter int unsigned DIR_SETUP_CYCLES = DIR_SETUP_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [COUNT_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic                step,
  output logic                dir,
  output logic                busy,
  output logic                move_done,
  output logic                aborted,
  output logic [COUNT_W-1:0]  steps_remaining
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  localparam logic [PERIOD_W-1:0] P_ONE      = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] HIGH_LEN   = PERIOD_W'(STEP_HIGH_CYCLES);
  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(STEP_HIGH_CYCLES + 1);
  localparam logic [PERIOD_W-1:0] SETUP_LOAD = PERIOD_W'(DIR_SETUP_CYCLES - 1);
  localparam logic [COUNT_W-1:0]  C_ZERO     = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0]  C_ONE      = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [1:0]          state_r;
  logic [1:0]          next_state_s;
  logic                accept_s;
  logic [PERIOD_W-1:0] cmd_eff_period_s;
  logic [PERIOD_W-1:0] eff_period_r;
  logic                tmr_load_s;
  logic [PERIOD_W-1:0] tmr_value_s;
  logic [PERIOD_W-1:0] tmr_count_s;
  logic                tmr_zero_s;
  logic                first_high_s;
  logic                high_last_s;
  logic                abort_pend_r;
  logic                move_end_s;
  logic                abort_end_s;
  logic                step_nxt_s;
  logic                dir_nxt_s;
  logic                busy_nxt_s;
  logic                ready_nxt_s;
  logic                step_r;
  logic                dir_r;
  logic                busy_r;
  logic                ready_r;
  logic                move_done_r;
  logic                aborted_r;
  logic [COUNT_W-1:0]  steps_rem_r;

  assign accept_s = cmd_valid && ready_r;

  // The timer is loaded with (interval - 1) at each rise. Elapsed time is
  // measured against that load value, so HIGH ends at eff-HIGH_LEN and LOW at 0.
  assign first_high_s = (state_r == ST_HIGH) && (tmr_count_s == (eff_period_r - P_ONE));
  assign high_last_s  = (tmr_count_s == (eff_period_r - HIGH_LEN));

  step_interval_timer #(
    .WIDTH (PERIOD_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load_s),
    .load_value (tmr_value_s),
    .count      (tmr_count_s),
    .zero       (tmr_zero_s)
  );

  // Clamp the requested period so every pulse keeps at least one low cycle
  always_comb begin
    if (cmd_period < MIN_PERIOD) begin
      cmd_eff_period_s = MIN_PERIOD;
    end else begin
      cmd_eff_period_s = cmd_period;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic, timer reloads and end-of-move detection
  always_comb begin
    next_state_s = state_r;
    tmr_load_s   = 1'b0;
    tmr_value_s  = {PERIOD_W{1'b0}};
    move_end_s   = 1'b0;
    abort_end_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (cmd_steps == C_ZERO) begin
            move_end_s = 1'b1;
          end else if (cmd_dir != dir_r) begin
            next_state_s = ST_SETUP;
            tmr_load_s   = 1'b1;
            tmr_value_s  = SETUP_LOAD;
          end else begin
            next_state_s = ST_HIGH;
            tmr_load_s   = 1'b1;
            tmr_value_s  = cmd_eff_period_s - P_ONE;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (abort) begin
          next_state_s = ST_IDLE;
          move_end_s   = 1'b1;
          abort_end_s  = 1'b1;
        end else if (tmr_zero_s) begin
          next_state_s = ST_HIGH;
          tmr_load_s   = 1'b1;
          tmr_value_s  = eff_period_r - P_ONE;
        end else begin
          next_state_s = ST_SETUP;
        end
      end
      ST_HIGH: begin
        // An abort seen during the pulse only takes effect once it has full width
        if (high_last_s) begin
          if (abort_pend_r || abort) begin
            next_state_s = ST_IDLE;
            move_end_s   = 1'b1;
            abort_end_s  = 1'b1;
          end else begin
            next_state_s = ST_LOW;
          end
        end else begin
          next_state_s = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (abort) begin
          next_state_s = ST_IDLE;
          move_end_s   = 1'b1;
          abort_end_s  = 1'b1;
        end else if (tmr_zero_s) begin
          if (steps_rem_r != C_ZERO) begin
            next_state_s = ST_HIGH;
            tmr_load_s   = 1'b1;
            tmr_value_s  = eff_period_r - P_ONE;
          end else begin
            next_state_s = ST_IDLE;
            move_end_s   = 1'b1;
          end
        end else begin
          next_state_s = ST_LOW;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so registered outputs align with it
  always_comb begin
    step_nxt_s  = (next_state_s == ST_HIGH);
    busy_nxt_s  = (next_state_s != ST_IDLE);
    ready_nxt_s = (next_state_s == ST_IDLE);
    if ((state_r == ST_IDLE) && (next_state_s == ST_SETUP)) begin
      dir_nxt_s = cmd_dir;
    end else begin
      dir_nxt_s = dir_r;
    end
  end

  // Output registers and per-move datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      step_r       <= 1'b0;
      dir_r        <= 1'b0;
      busy_r       <= 1'b0;
      ready_r      <= 1'b1;
      move_done_r  <= 1'b0;
      aborted_r    <= 1'b0;
      steps_rem_r  <= C_ZERO;
      eff_period_r <= MIN_PERIOD;
      abort_pend_r <= 1'b0;
    end else begin
      step_r      <= step_nxt_s;
      dir_r       <= dir_nxt_s;
      busy_r      <= busy_nxt_s;
      ready_r     <= ready_nxt_s;
      move_done_r <= move_end_s;
      if (accept_s) begin
        aborted_r <= 1'b0;
      end else if (abort_end_s) begin
        aborted_r <= 1'b1;
      end else begin
        aborted_r <= aborted_r;
      end
      if (accept_s) begin
        steps_rem_r  <= cmd_steps;
        eff_period_r <= cmd_eff_period_s;
      end else if (first_high_s && (steps_rem_r != C_ZERO)) begin
        steps_rem_r <= steps_rem_r - C_ONE;
      end else begin
        steps_rem_r <= steps_rem_r;
      end
      if (next_state_s != ST_HIGH) begin
        abort_pend_r <= 1'b0;
      end else if ((state_r == ST_HIGH) && abort) begin
        abort_pend_r <= 1'b1;
      end else begin
        abort_pend_r <= abort_pend_r;
      end
    end
  end

  assign step            = step_r;
  assign dir             = dir_r;
  assign busy            = busy_r;
  assign cmd_ready       = ready_r;
  assign move_done       = move_done_r;
  assign aborted         = aborted_r;
  assign steps_remaining = steps_rem_r;

endmodule : step_dir_pulse_gen

// File: tb/tb_step_dir_pulse_gen.sv
// Directed bench for step_dir_pulse_gen. Expected STEP edges and move_done
// pulses (cycle and aborted flag) are queued when a command is issued.
// A negedge monitor pops them as the DUT produces them.
module tb_step_dir_pulse_gen;

  typedef struct {
    int   c;
    logic ab;
  } done_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cmd_steps = 32'd0;
  logic [31:0] cmd_period = 32'd0;
  logic        cmd_ready;
  logic        step;
  logic        dir;
  logic        busy;
  logic        move_done;
  logic        aborted;
  logic [31:0] steps_remaining;

  int    cyc = 0;
  int    n_total = 0;
  int    n_pass = 0;
  int    rise_q[$];
  int    fall_q[$];
  done_t done_q[$];
  logic  prev_step = 1'b0;
  int    mon_c;
  done_t mon_d;
  int    t;

  step_dir_pulse_gen dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_dir         (cmd_dir),
    .cmd_steps       (cmd_steps),
    .cmd_period      (cmd_period),
    .abort           (abort),
    .step            (step),
    .dir             (dir),
    .busy            (busy),
    .move_done       (move_done),
    .aborted         (aborted),
    .steps_remaining (steps_remaining)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push_done(input int c, input logic ab);
    done_t d;
    d.c  = c;
    d.ab = ab;
    done_q.push_back(d);
  endtask

  // Called at a negedge; the accept edge ends cycle t, so t+1 is the first cycle after
  task automatic issue(input logic d, input logic [31:0] n, input logic [31:0] p, output int ta);
    cmd_dir    = d;
    cmd_steps  = n;
    cmd_period = p;
    cmd_valid  = 1'b1;
    ta         = cyc;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((done_q.size() != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", done_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: match STEP edges and move_done pulses against the scoreboard
  always @(negedge clk) begin
    if (step && !prev_step) begin
      if (rise_q.size() == 0) check("rise_unexpected", cyc, 0);
      else begin
        mon_c = rise_q.pop_front();
        check("rise_cycle", cyc, mon_c);
      end
    end
    if (!step && prev_step) begin
      if (fall_q.size() == 0) check("fall_unexpected", cyc, 0);
      else begin
        mon_c = fall_q.pop_front();
        check("fall_cycle", cyc, mon_c);
      end
    end
    if (move_done) begin
      if (done_q.size() == 0) check("done_unexpected", cyc, 0);
      else begin
        mon_d = done_q.pop_front();
        check("done_cycle", cyc, mon_d.c);
        check("done_aborted", aborted, mon_d.ab);
      end
    end
    prev_step <= step;
  end

  initial begin
    // Reset held 4 cycles
    repeat (4) @(negedge clk);
    reset = 1'b0;
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_steps_rem", steps_remaining, 0);
    check("rst_done", move_done, 0);
    check("rst_aborted", aborted, 0);

    // 3 steps, period 20, same direction
    t = cyc;
    rise_q.push_back(t + 1);  rise_q.push_back(t + 21); rise_q.push_back(t + 41);
    fall_q.push_back(t + 9);  fall_q.push_back(t + 29); fall_q.push_back(t + 49);
    push_done(t + 61, 1'b0);
    issue(1'b0, 32'd3, 32'd20, t);
    goto(t + 2);
    check("m3_busy", busy, 1);
    check("m3_ready", cmd_ready, 0);
    check("m3_rem_a", steps_remaining, 2);
    goto(t + 22);
    check("m3_rem_b", steps_remaining, 1);
    goto(t + 42);
    check("m3_rem_c", steps_remaining, 0);
    goto(t + 61);
    check("m3_ready_at_done", cmd_ready, 1);
    wait_idle(200);

    // Direction change: DIR setup before the first rise
    t = cyc;
    rise_q.push_back(t + 17);
    fall_q.push_back(t + 25);
    push_done(t + 37, 1'b0);
    issue(1'b1, 32'd1, 32'd20, t);
    check("dir_changed", dir, 1);
    check("dir_step_low", step, 0);
    check("dir_busy", busy, 1);
    goto(t + 18);
    check("dir_rem", steps_remaining, 0);
    wait_idle(200);

    // Period below minimum is clamped to high+1
    t = cyc;
    rise_q.push_back(t + 1); rise_q.push_back(t + 10);
    fall_q.push_back(t + 9); fall_q.push_back(t + 18);
    push_done(t + 19, 1'b0);
    issue(1'b1, 32'd2, 32'd2, t);
    wait_idle(200);

    // Abort in the 3rd HIGH cycle of the 2nd of 5 pulses
    t = cyc;
    rise_q.push_back(t + 1); rise_q.push_back(t + 21);
    fall_q.push_back(t + 9); fall_q.push_back(t + 29);
    push_done(t + 29, 1'b1);
    issue(1'b1, 32'd5, 32'd20, t);
    goto(t + 23);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    goto(t + 29);
    check("abh_rem", steps_remaining, 3);
    check("abh_aborted", aborted, 1);
    check("abh_dir_held", dir, 1);
    wait_idle(200);

    // Abort during LOW: next cycle idle, remaining count held
    t = cyc;
    rise_q.push_back(t + 1);
    fall_q.push_back(t + 9);
    push_done(t + 13, 1'b1);
    issue(1'b1, 32'd4, 32'd20, t);
    check("abl_aborted_cleared", aborted, 0);
    goto(t + 12);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abl_rem_held", steps_remaining, 3);
    check("abl_busy", busy, 0);
    wait_idle(200);

    // Zero steps: immediate done, DIR untouched even though requested differs
    t = cyc;
    push_done(t + 1, 1'b0);
    issue(1'b0, 32'd0, 32'd20, t);
    check("zero_dir", dir, 1);
    check("zero_busy", busy, 0);
    check("zero_ready", cmd_ready, 1);
    check("zero_aborted", aborted, 0);
    wait_idle(200);

    // Abort together with cmd_valid in IDLE: command accepted normally
    abort = 1'b1;
    t = cyc;
    rise_q.push_back(t + 1);
    fall_q.push_back(t + 9);
    push_done(t + 11, 1'b0);
    issue(1'b1, 32'd1, 32'd10, t);
    abort = 1'b0;
    wait_idle(200);

    // Reset asserted mid-HIGH
    t = cyc;
    rise_q.push_back(t + 1);
    fall_q.push_back(t + 4);
    issue(1'b1, 32'd2, 32'd20, t);
    goto(t + 3);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_step", step, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", cmd_ready, 1);
    check("rst_mid_dir", dir, 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    check("rise_q_empty", rise_q.size(), 0);
    check("fall_q_empty", fall_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_step_dir_pulse_gen
